// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encodings and round-function helpers.
// Byte i of a 128-bit block sits at bits [127-8*i -: 8], column-major.
package aes_pkg;

    localparam int AES_NR    = 14;
    localparam int AES_BLK_W = 128;
    localparam int AES_RK_W  = 128 * (AES_NR + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Column word is {a0, a1, a2, a3} with row 0 in the MSBs.
    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+row)%4)+row) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rk_slice(input logic [AES_RK_W-1:0] rk,
                                              input logic [3:0] idx);
        return rk[AES_RK_W-1-128*int'(idx) -: 128];
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] x,
    output logic [7:0] y
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX[x];

endmodule

// File: rtl/aes256_enc_core.sv
// Iterative AES-256 encryptor, one round per clock, valid/ready on both sides.
//   state   | meaning
//   IDLE    | in_ready high, waiting for a plaintext block
//   RUN     | applying rounds 1..NR, counter holds the round being applied
//   DONE    | out_valid high, ciphertext held until out_ready
module aes256_enc_core
    import aes_pkg::*;
#(
    parameter int NR   = 14,
    parameter int RK_W = 1920
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [RK_W-1:0]      round_keys,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] out_data
);

    logic [1:0]   fsm;
    logic [3:0]   cnt;
    logic [127:0] st;
    logic [127:0] sb;
    logic [127:0] sr;
    logic [127:0] mc;
    logic [127:0] nxt;

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_sbox u_sbox (
            .x(st[127-8*i -: 8]),
            .y(sb[127-8*i -: 8])
        );
    end

    // Final round skips MixColumns.
    always_comb begin
        sr = shift_rows(sb);
        mc = '0;
        for (int c = 0; c < 4; c++) begin
            mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
        end
        nxt = ((cnt == 4'(NR)) ? sr : mc) ^ rk_slice(round_keys, cnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm      <= ST_IDLE;
            cnt      <= 4'd0;
            st       <= '0;
            out_data <= '0;
        end else begin
            case (fsm)
                ST_IDLE: begin
                    if (in_valid) begin
                        st  <= in_data ^ rk_slice(round_keys, 4'd0);
                        cnt <= 4'd1;
                        fsm <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    st <= nxt;
                    if (cnt == 4'(NR)) begin
                        out_data <= nxt;
                        cnt      <= 4'd0;
                        fsm      <= ST_DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        fsm <= ST_IDLE;
                    end
                end
                default: fsm <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (fsm == ST_IDLE);
    assign out_valid = (fsm == ST_DONE);

endmodule

// File: tb/tb_aes256_enc_core.sv
// Scoreboard bench for aes256_enc_core: directed FIPS-197 vectors plus a byte-array software model.
module tb_aes256_enc_core;

    localparam logic [255:0] C3KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C3CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] ZCT   = 128'hdc95c078a2408989ad48a21492842087;

    logic          clk;
    logic          rst;
    logic [1919:0] round_keys;
    logic          in_valid;
    logic          in_ready;
    logic [127:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  out_data;

    aes256_enc_core dut (
        .clk       (clk),
        .rst       (rst),
        .round_keys(round_keys),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total  = 0;
    int passed = 0;
    logic [127:0] exp_q[$];
    int           acc_q[$];
    logic [7:0]   tsbox[256];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        total++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // S-box derived from the GF(2^8) inverse and the affine map.
    function automatic logic [7:0] sb_calc(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h01;
        if (a == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {tsbox[t[31:24]], tsbox[t[23:16]], tsbox[t[15:8]], tsbox[t[7:0]]};
    endfunction

    function automatic logic [1919:0] expand_key(input logic [255:0] key);
        logic [31:0]   w[60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] bus;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = subw({t[23:0], t[31:24]});
                t[31:24] = t[31:24] ^ rc;
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int i = 0; i < 60; i++) bus[1919-32*i -: 32] = w[i];
        return bus;
    endfunction

    function automatic logic [127:0] model_enc(input logic [1919:0] rks, input logic [127:0] pt);
        logic [7:0]   s[16];
        logic [7:0]   t[16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rks[1919-8*i -: 8];
        for (int rnd = 1; rnd <= 14; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = tsbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[row+4*c] = t[row+4*((c+row)%4)];
            if (rnd < 14) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rks[1919-128*rnd-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
        return r;
    endfunction

    // Monitor: pops and compares on every output handshake.
    initial begin
        bit prev_valid, prev_hs, hs;
        int rise_cyc, a;
        logic [127:0] e;
        prev_valid = 0; prev_hs = 0; rise_cyc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 0;
                prev_hs    = 0;
            end else begin
                if (prev_hs) check("valid_after_handoff", {127'd0, out_valid}, 128'd0);
                if (out_valid && !prev_valid) rise_cyc = cyc;
                hs = out_valid && out_ready;
                if (hs) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_output");
                    end else begin
                        e = exp_q.pop_front();
                        a = acc_q.pop_front();
                        check("ciphertext", out_data, e);
                        check("latency", 128'(rise_cyc - a), 128'd14);
                    end
                end
                prev_valid = out_valid;
                prev_hs    = hs;
            end
        end
    end

    task automatic send(input logic [127:0] pt, input logic [127:0] exp, input bit push);
        int n;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = pt;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) begin
            fail_now("accept_timeout");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (push) begin
            exp_q.push_back(exp);
            acc_q.push_back(cyc);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || out_valid) && n < 300);
        if (exp_q.size() != 0 || out_valid) fail_now("drain_timeout");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1919:0] c3rk;
        logic [127:0]  pts[4];
        int            accs[4];
        int            n, seen;

        for (int i = 0; i < 256; i++) tsbox[i] = sb_calc(8'(i));
        c3rk = expand_key(C3KEY);

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; round_keys = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", {127'd0, in_ready}, 128'd1);
        check("reset_out_valid", {127'd0, out_valid}, 128'd0);
        check("reset_out_data", out_data, 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // FIPS-197 C.3
        round_keys = c3rk;
        out_ready  = 1'b1;
        send(C3PT, C3CT, 1'b1);
        wait_drain();

        // All-zero key and plaintext
        round_keys = expand_key(256'd0);
        send(128'd0, ZCT, 1'b1);
        wait_drain();

        // Output back-pressure with a stray in_valid
        round_keys = c3rk;
        out_ready  = 1'b0;
        send(C3PT, C3CT, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 100);
        if (!out_valid) fail_now("bp_valid_timeout");
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 128'd0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("bp_out_valid", {127'd0, out_valid}, 128'd1);
            check("bp_out_data", out_data, C3CT);
            check("bp_in_ready", {127'd0, in_ready}, 128'd0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready_low", {127'd0, in_ready}, 128'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_in_ready_rise", {127'd0, in_ready}, 128'd1);
        check("bp_out_valid_drop", {127'd0, out_valid}, 128'd0);
        wait_drain();

        // Reset in the middle of a run
        send(C3PT, C3CT, 1'b0);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", {127'd0, in_ready}, 128'd1);
        check("midrst_out_valid", {127'd0, out_valid}, 128'd0);
        check("midrst_out_data", out_data, 128'd0);
        send(C3PT, C3CT, 1'b1);
        wait_drain();

        // Back-to-back stream with in_valid held high
        for (int i = 0; i < 4; i++) pts[i] = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = pts[0];
        for (int i = 0; i < 4; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!in_ready && n < 100);
            if (!in_ready) begin
                fail_now("stream_accept_timeout");
                break;
            end
            @(posedge clk); #1;
            accs[i] = cyc;
            exp_q.push_back(model_enc(c3rk, pts[i]));
            acc_q.push_back(cyc);
            if (i < 3) in_data = pts[i+1];
        end
        in_valid = 1'b0;
        for (int i = 1; i < 4; i++) check("stream_spacing", 128'(accs[i] - accs[i-1]), 128'd16);
        wait_drain();

        // Reset and in_valid on the same edge
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b1; in_data = C3PT;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("collision_no_accept", {127'd0, in_ready}, 128'd1);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("collision_no_output", 128'(seen), 128'd0);

        check("queue_empty", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
